// File: rtl/obi_data_responder.sv
// OBI data-port responder: word-addressed scratch memory behind a small
// in-order response FIFO, with a fixed minimum response latency and optional
// pseudo-random grant stalls (enabled by defining OBI_RESP_STALL_EN).
//
// Handshake: a request is accepted in a cycle where data_req_i and data_gnt_o
// are both high at the rising edge. Responses carry no ready: data_rvalid_o is
// high for exactly one cycle per accepted request, in acceptance order, and
// data_rdata_o / data_err_o are only meaningful (otherwise 0) while it is high.
module obi_data_responder #(
    parameter int          ADDR_WIDTH      = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          RESP_LATENCY    = 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        stall_en_i,
    input  logic [3:0]  stall_thresh_i
);

    localparam logic [2:0]  MAX_CNT      = 3'(MAX_OUTSTANDING);
    localparam logic [1:0]  LAST_PTR     = 2'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]  LAT_LOAD     = 4'(RESP_LATENCY - 1);
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * (2 ** ADDR_WIDTH));

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [31:0]           fifo_rdata [4];
    logic [3:0]            fifo_err;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count;
    logic [3:0]            head_cnt;

    logic                  stall;
    logic                  accept;
    logic                  pop;
    logic                  new_head;
    logic                  out_of_range;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] index;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef OBI_RESP_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) advancing every cycle out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = stall_en_i && (lfsr[3:0] < stall_thresh_i);
`else
    // Stall inputs stay on the port list but have no effect in this build.
    logic unused_stall_inputs;
    assign unused_stall_inputs = ^{stall_en_i, stall_thresh_i, LFSR_SEED};
    assign stall = 1'b0;
`endif

    // Addresses below the base wrap to huge offsets and land out of range.
    assign offset       = data_addr_i - BASE_ADDR;
    assign index        = offset[ADDR_WIDTH+1:2];
    assign out_of_range = (offset >= WINDOW_BYTES);

    // Occupancy is the registered count, so a pop this cycle frees its slot next cycle.
    assign data_gnt_o = rst_ni && data_req_i && !stall && (count < MAX_CNT);
    assign accept     = data_gnt_o;

    assign pop           = (count != 3'd0) && (head_cnt == 4'd0);
    assign data_rvalid_o = pop;
    assign data_rdata_o  = pop ? fifo_rdata[rd_ptr] : 32'h0;
    assign data_err_o    = pop && fifo_err[rd_ptr];

    // An entry becomes head when pushed into an empty FIFO or when the entry ahead pops.
    assign new_head = (accept && (count == 3'd0)) || (pop && ((count > 3'd1) || accept));

    // FIFO pointers, occupancy and head latency counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            head_cnt <= 4'd0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (new_head) begin
                head_cnt <= LAT_LOAD;
            end else if (head_cnt != 4'd0) begin
                head_cnt <= head_cnt - 4'd1;
            end
        end
    end

    // Memory update and response capture on accept; storage is never reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_err[wr_ptr]   <= out_of_range;
            fifo_rdata[wr_ptr] <= (data_we_i || out_of_range) ? 32'h0 : mem[index];
            if (data_we_i && !out_of_range) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be_i[b]) begin
                        mem[index][8*b +: 8] <= data_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_data_responder.sv
// Testbench for obi_data_responder: one instance at latency 1 and one at
// latency 3, exercised one at a time against a timestamped response model.
module tb_obi_data_responder;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int          MAXO = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]        req, we, stall_en, gnt, rvalid, err;
    logic [1:0][31:0]  addr, wdata, rdata;
    logic [1:0][3:0]   be, thr;

    resp_t       exp_q[$];
    logic [31:0] mem_m [2][1024];
    int          lat [2];
    int          resp_edges[$];
    int          u, edge_n, checks, errors, last_cycles, stalls_seen;
    logic        last_acc, last_err;
    logic [31:0] last_rdata;

    // Clock.
    always #5 clk = ~clk;

    obi_data_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO),
                         .RESP_LATENCY(1), .LFSR_SEED(16'hACE1)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]),
        .stall_en_i(stall_en[0]), .stall_thresh_i(thr[0]));

    obi_data_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO),
                         .RESP_LATENCY(3), .LFSR_SEED(16'hACE1)) u_slow (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]),
        .stall_en_i(stall_en[1]), .stall_thresh_i(thr[1]));

    // One clock cycle on the active instance: compare outputs with the model,
    // then advance the model across the rising edge. Entered and left at negedge.
    task automatic tick(input string tag);
        int          nxt, prev;
        logic        e_rv, e_er, e_gnt, allow, acc, oor;
        logic [31:0] e_rd, off;
        logic [9:0]  idx;
        resp_t       ent;
        #1;
        nxt   = edge_n + 1;
        e_rv  = (exp_q.size() != 0) && (exp_q[0].due == nxt);
        e_rd  = e_rv ? exp_q[0].data : 32'h0;
        e_er  = e_rv ? exp_q[0].err : 1'b0;
        e_gnt = req[u] && (exp_q.size() < MAXO);
`ifdef OBI_RESP_STALL_EN
        allow = stall_en[u] && (thr[u] != 4'h0);
`else
        allow = 1'b0;
`endif
        checks++;
        if (allow ? (gnt[u] && !e_gnt) : (gnt[u] !== e_gnt)) begin
            errors++;
            $display("FAIL %s gnt: got %b expected %b at edge %0d", tag, gnt[u], e_gnt, nxt);
        end
        if (e_gnt && gnt[u] === 1'b0) stalls_seen++;
        checks++;
        if (rvalid[u] !== e_rv || err[u] !== e_er || rdata[u] !== e_rd) begin
            errors++;
            $display("FAIL %s resp: got rvalid=%b err=%b rdata=%h expected rvalid=%b err=%b rdata=%h at edge %0d",
                     tag, rvalid[u], err[u], rdata[u], e_rv, e_er, e_rd, nxt);
        end
        checks++;
        if (rvalid[1-u] !== 1'b0 || gnt[1-u] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_unit: got rvalid=%b gnt=%b expected 0 0", tag, rvalid[1-u], gnt[1-u]);
        end
        if (e_rv) begin
            last_rdata = rdata[u];
            last_err   = err[u];
            resp_edges.push_back(nxt);
        end
        acc = allow ? (gnt[u] === 1'b1) : e_gnt;
        @(posedge clk);
        edge_n = nxt;
        if (acc) begin
            off      = addr[u] - BASE;
            oor      = (off >= 32'h1000);
            idx      = off[11:2];
            ent.err  = oor;
            ent.data = 32'h0;
            if (!oor) begin
                if (we[u]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[u][b]) mem_m[u][idx][8*b +: 8] = wdata[u][8*b +: 8];
                end else begin
                    ent.data = mem_m[u][idx];
                end
            end
            prev    = (exp_q.size() != 0) ? exp_q[exp_q.size()-1].due : 0;
            ent.due = ((prev > nxt) ? prev : nxt) + lat[u];
            exp_q.push_back(ent);
        end
        if (e_rv) void'(exp_q.pop_front());
        last_acc = acc;
        @(negedge clk);
    endtask

    // Present one request and hold it until granted (bounded).
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input int bound, input string tag);
        int n;
        n = 0;
        req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = d;
        last_acc = 1'b0;
        while (!last_acc && n < bound) begin
            tick(tag);
            n++;
        end
        last_cycles = n;
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL %s grant_timeout: got no grant in %0d cycles, required a grant", tag, n);
        end
    endtask

    // Drop the request and wait until every expected response has appeared.
    task automatic drain();
        int n;
        n = 0;
        req[u] = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            tick("drain");
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; addr = '{BASE, BASE}; be = '{4'hF, 4'hF};
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got gnt=%b rvalid=%b err=%b rdata=%h expected all 0",
                         i, gnt[i], rvalid[i], err[i], rdata[i]);
            end
        end
        repeat (2) begin
            @(posedge clk); edge_n++; @(negedge clk);
        end
        req = 2'b00;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic preload(input int ui);
        u = ui;
        for (int i = 0; i < 16; i++) issue(1'b1, BASE + 32'(4*i), 4'hF, $urandom, 20, "preload");
        drain();
    endtask

    task automatic test_write_read();
        int acc_edge;
        u = 0;
        issue(1'b1, BASE + 32'h8, 4'hF, 32'hDEADBEEF, 20, "wr_full");
        drain();
        resp_edges.delete();
        issue(1'b0, BASE + 32'h8, 4'hF, 32'h0, 20, "rd_full");
        acc_edge = edge_n;
        checks++;
        if (last_cycles !== 1) begin
            errors++;
            $display("FAIL rd_gnt_latency: got %0d cycles, required 1", last_cycles);
        end
        drain();
        checks++;
        if (resp_edges.size() != 1 || resp_edges[0] != acc_edge + 1 || last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_full_data: got rdata=%h err=%b, required DEADBEEF 0 one cycle after accept", last_rdata, last_err);
        end
    endtask

    task automatic test_partial_write();
        u = 0;
        issue(1'b1, BASE + 32'h8, 4'b0001, 32'h0000_00AA, 20, "wr_byte");
        drain();
        issue(1'b0, BASE + 32'hA, 4'h0, 32'h0, 20, "rd_byte");
        drain();
        checks++;
        if (last_rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL partial_write: got %h, required DEADBEAA", last_rdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] oor_addr [2];
        u = 0;
        oor_addr[0] = BASE + 32'h1000;
        oor_addr[1] = BASE - 32'h4;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, oor_addr[i], 4'hF, 32'h0, 20, "rd_oor");
            drain();
            checks++;
            if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
                errors++;
                $display("FAIL oor_read[%0d]: got err=%b rdata=%h, required 1 00000000", i, last_err, last_rdata);
            end
        end
        issue(1'b1, BASE + 32'h1000, 4'hF, 32'h1234_5678, 20, "wr_oor");
        drain();
        issue(1'b0, BASE, 4'hF, 32'h0, 20, "rd_after_oor");
        drain();
        checks++;
        if (last_err !== 1'b0 || last_rdata === 32'h1234_5678) begin
            errors++;
            $display("FAIL oor_write_leak: got err=%b rdata=%h, required err 0 and word 0 untouched", last_err, last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        u = 0; total = 0;
        resp_edges.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, BASE + 32'(4*i), 4'hF, 32'h0, 20, "b2b");
            total += last_cycles;
        end
        drain();
        checks++;
        if (total != 4 || resp_edges.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d cycles %0d responses, required 4 4", total, resp_edges.size());
        end
        for (int i = 1; i < resp_edges.size(); i++) begin
            checks++;
            if (resp_edges[i] - resp_edges[i-1] != 1) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d, required 1", i, resp_edges[i] - resp_edges[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int total;
        u = 1; total = 0;
        resp_edges.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, BASE + 32'(4*(i+4)), 4'hF, 32'h0, 30, "bp");
            total += last_cycles;
        end
        drain();
        checks++;
        if (total <= 4 || resp_edges.size() != 4) begin
            errors++;
            $display("FAIL bp_stall: got %0d cycles %0d responses, required more than 4 cycles and 4 responses", total, resp_edges.size());
        end
        for (int i = 1; i < resp_edges.size(); i++) begin
            checks++;
            if (resp_edges[i] - resp_edges[i-1] < 3) begin
                errors++;
                $display("FAIL bp_spacing[%0d]: got %0d, required at least 3", i, resp_edges[i] - resp_edges[i-1]);
            end
        end
    endtask

    task automatic test_random(input int ui, input int n, input int bound);
        logic [31:0] a;
        int k;
        u = ui;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req[u] = 1'b0;
                repeat ($urandom_range(1, 2)) tick("gap");
            end
            k = $urandom_range(0, 9);
            if (k == 0)      a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
            else if (k == 1) a = BASE - 32'(4 * $urandom_range(1, 64));
            else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, bound, "random");
        end
        drain();
    endtask

    task automatic test_stall();
        u = 0;
        stall_en[0] = 1'b1; thr[0] = 4'hF; stalls_seen = 0;
        test_random(0, 200, 2000);
        checks++;
`ifdef OBI_RESP_STALL_EN
        if (stalls_seen == 0) begin
            errors++;
            $display("FAIL stall_seen: got 0 withheld grants, required some");
        end
`else
        if (stalls_seen != 0) begin
            errors++;
            $display("FAIL stall_disabled: got %0d withheld grants, required 0", stalls_seen);
        end
`endif
        thr[0] = 4'h0; stalls_seen = 0;
        test_random(0, 50, 20);
        checks++;
        if (stalls_seen != 0) begin
            errors++;
            $display("FAIL stall_thresh0: got %0d withheld grants, required 0", stalls_seen);
        end
        stall_en[0] = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int n;
        u = 1; n = 0;
        issue(1'b0, BASE + 32'h4, 4'hF, 32'h0, 20, "mf_a");
        issue(1'b0, BASE + 32'h8, 4'hF, 32'h0, 20, "mf_b");
        req[1] = 1'b0;
        while (exp_q.size() != 0 && exp_q[0].due != edge_n + 1 && n < 10) begin
            tick("mf_wait");
            n++;
        end
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL mf_pending: got %0d pending, required 2", exp_q.size());
        end
        req[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid[1] !== 1'b0 || gnt[1] !== 1'b0 || rdata[1] !== 32'h0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL mf_reset_outputs: got rvalid=%b gnt=%b rdata=%h err=%b expected all 0",
                     rvalid[1], gnt[1], rdata[1], err[1]);
        end
        exp_q.delete();
        repeat (2) begin
            @(posedge clk); edge_n++; @(negedge clk);
        end
        req[1] = 1'b0;
        rst_n = 1'b1;
        repeat (8) tick("mf_no_stale");
        issue(1'b0, BASE + 32'h4, 4'hF, 32'h0, 20, "mf_after");
        checks++;
        if (last_cycles !== 1) begin
            errors++;
            $display("FAIL mf_occupancy: got grant after %0d cycles, required 1", last_cycles);
        end
        issue(1'b0, BASE + 32'hC, 4'hF, 32'h0, 20, "mf_after2");
        drain();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; edge_n = 0; stalls_seen = 0;
        lat[0] = 1; lat[1] = 3;
        req = 2'b00; we = 2'b00; stall_en = 2'b00;
        addr = '0; wdata = '0; be = '0; thr = '0;
        test_reset();
        preload(0);
        preload(1);
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_random(0, 150, 20);
        test_random(1, 150, 20);
        test_stall();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
